// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_frame_tx #(
    parameter int DATA_W   = 4,
    parameter int BAUD_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        fsm_state
);

    localparam int BW = $clog2(BAUD_DIV) + 1;
    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [CW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [BW-1:0]     baud_cnt_q, baud_cnt_d;
    logic              ser_q,      ser_d;
    logic              done_q,     done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              parity_q,   parity_d;
`endif

    logic [DATA_W-1:0] shreg_shift;
    logic              baud_end;

    assign shreg_shift = shreg_q >> 1;
    assign baud_end    = (baud_cnt_q == BAUD_LAST);

    assign data_ready = (state_q == IDLE) && !reset;
    assign serial_out = ser_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign fsm_state  = state_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        ser_d      = ser_q;
        done_d     = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        // The baud counter free-runs inside a frame and wraps at every bit boundary.
        if (state_q != IDLE) begin
            baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                if (data_valid) begin
                    shreg_d    = data_in;
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    ser_d      = 1'b0;
                    state_d    = START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_d   = ^data_in;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    ser_d     = shreg_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    shreg_d = shreg_shift;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = PARITY;
                        ser_d   = parity_q;
`else
                        state_d = STOP;
                        ser_d   = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        ser_d     = shreg_shift[0];
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    ser_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                ser_d = 1'b1;
                if (baud_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                ser_d      = 1'b1;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            ser_q      <= 1'b1;
            done_q     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            ser_q      <= ser_d;
            done_q     <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (4b/div2, 4b/div1, 1b/div3) driven from a frame table
// plus hand-written reset, back-to-back and hold-off sequences.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset;
    logic [3:0] din_a, din_b;
    logic       din_c;
    logic       val_a, val_b, val_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       so_a, so_b, so_c;
    logic       busy_a, busy_b, busy_c;
    logic       fd_a, fd_b, fd_c;
    logic [2:0] st_a, st_b, st_c;

    serial_frame_tx #(.DATA_W(4), .BAUD_DIV(2)) u_d4b2 (
        .clk(clk), .reset(reset), .data_in(din_a), .data_valid(val_a), .data_ready(rdy_a),
        .serial_out(so_a), .busy(busy_a), .frame_done(fd_a), .fsm_state(st_a));
    serial_frame_tx #(.DATA_W(4), .BAUD_DIV(1)) u_d4b1 (
        .clk(clk), .reset(reset), .data_in(din_b), .data_valid(val_b), .data_ready(rdy_b),
        .serial_out(so_b), .busy(busy_b), .frame_done(fd_b), .fsm_state(st_b));
    serial_frame_tx #(.DATA_W(1), .BAUD_DIV(3)) u_d1b3 (
        .clk(clk), .reset(reset), .data_in(din_c), .data_valid(val_c), .data_ready(rdy_c),
        .serial_out(so_c), .busy(busy_c), .frame_done(fd_c), .fsm_state(st_c));

    int sel = 0;
    logic so_m, busy_m, fd_m, rdy_m;
    logic [2:0] st_m;
    assign so_m   = (sel == 0) ? so_a   : (sel == 1) ? so_b   : so_c;
    assign busy_m = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    assign fd_m   = (sel == 0) ? fd_a   : (sel == 1) ? fd_b   : fd_c;
    assign rdy_m  = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
    assign st_m   = (sel == 0) ? st_a   : (sel == 1) ? st_b   : st_c;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        int         sel;
        logic [3:0] data;
        int         nbits_np;
        logic [7:0] bits_np;
        logic [7:0] bits_par;
    } vec_t;

    vec_t vecs[10];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int baud_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 1 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, cycle %0d): got %0h, expected %0h", name, sel, cyc, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] d);
        val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
        case (sel)
            0:       begin val_a = v; din_a = d; end
            1:       begin val_b = v; din_b = d; end
            default: begin val_c = v; din_c = d[0]; end
        endcase
    endtask

    // Called the cycle after the accepting edge; returns in the first idle cycle.
    task automatic check_frame(input logic [7:0] bits, input int nbits, input string tag);
        int b;
        b = baud_of(sel);
        for (int i = 0; i < nbits * b; i++) begin
            chk({tag, " serial_out"}, {7'd0, so_m}, {7'd0, bits[i / b]});
            chk({tag, " busy"}, {7'd0, busy_m}, 8'd1);
            chk({tag, " frame_done low"}, {7'd0, fd_m}, 8'd0);
            chk({tag, " data_ready low"}, {7'd0, rdy_m}, 8'd0);
            tick();
        end
        chk({tag, " idle line"}, {7'd0, so_m}, 8'd1);
        chk({tag, " busy fall"}, {7'd0, busy_m}, 8'd0);
        chk({tag, " frame_done pulse"}, {7'd0, fd_m}, 8'd1);
        chk({tag, " data_ready idle"}, {7'd0, rdy_m}, 8'd1);
    endtask

    task automatic send_vec(input int idx);
        logic [7:0] bits;
        int nb;
        sel  = vecs[idx].sel;
        bits = (PAR != 0) ? vecs[idx].bits_par : vecs[idx].bits_np;
        nb   = vecs[idx].nbits_np + PAR;
        #1;
        set_in(1'b1, vecs[idx].data);
        tick();
        set_in(1'b0, 4'h0);
        check_frame(bits, nb, $sformatf("vec%0d", idx));
        tick();
        chk("frame_done one cycle", {7'd0, fd_m}, 8'd0);
        chk("line idle after frame", {7'd0, so_m}, 8'd1);
    endtask

    function automatic logic [7:0] vbits(input int idx);
        return (PAR != 0) ? vecs[idx].bits_par : vecs[idx].bits_np;
    endfunction

    initial begin
        int c1, c2;
        vecs[0] = '{0, 4'b1011, 6, 8'b0011_0110, 8'b0111_0110};
        vecs[1] = '{0, 4'h0,    6, 8'b0010_0000, 8'b0100_0000};
        vecs[2] = '{0, 4'hF,    6, 8'b0011_1110, 8'b0101_1110};
        vecs[3] = '{0, 4'b0011, 6, 8'b0010_0110, 8'b0100_0110};
        vecs[4] = '{0, 4'h6,    6, 8'b0010_1100, 8'b0100_1100};
        vecs[5] = '{1, 4'hA,    6, 8'b0011_0100, 8'b0101_0100};
        vecs[6] = '{1, 4'h5,    6, 8'b0010_1010, 8'b0100_1010};
        vecs[7] = '{1, 4'b1011, 6, 8'b0011_0110, 8'b0111_0110};
        vecs[8] = '{2, 4'h1,    3, 8'b0000_0110, 8'b0000_1110};
        vecs[9] = '{2, 4'h0,    3, 8'b0000_0100, 8'b0000_1000};

        reset = 1'b1;
        din_a = 4'h0; din_b = 4'h0; din_c = 1'b0;
        val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset serial_out", {7'd0, so_m}, 8'd1);
            chk("reset busy", {7'd0, busy_m}, 8'd0);
            chk("reset frame_done", {7'd0, fd_m}, 8'd0);
            chk("reset data_ready", {7'd0, rdy_m}, 8'd0);
            chk("reset state", {5'd0, st_m}, 8'd0);
        end
        reset = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("ready after reset", {7'd0, rdy_m}, 8'd1);
        end
        tick();

        for (int i = 0; i < 10; i++) send_vec(i);

        // Back-to-back on the divide-by-1 instance with valid held high.
        sel = 1;
        #1;
        set_in(1'b1, 4'hA);
        tick();
        set_in(1'b1, 4'h5);
        check_frame(vbits(5), 6 + PAR, "b2b first");
        c1 = cyc;
        tick();
        set_in(1'b0, 4'h0);
        check_frame(vbits(6), 6 + PAR, "b2b second");
        c2 = cyc;
        chk("b2b frame_done spacing", 8'(c2 - c1), 8'(7 + PAR));
        tick();
        chk("b2b done low", {7'd0, fd_m}, 8'd1 - 8'd1 + {7'd0, fd_m} - {7'd0, fd_m});

        // Hold-off: valid with 4'hF raised during a frame is taken only once idle.
        sel = 0;
        #1;
        set_in(1'b1, 4'h0);
        tick();
        set_in(1'b1, 4'hF);
        check_frame(vbits(1), 6 + PAR, "holdoff busy");
        tick();
        set_in(1'b0, 4'h0);
        check_frame(vbits(2), 6 + PAR, "holdoff accepted");
        tick();
        chk("holdoff no extra frame", {7'd0, busy_m}, 8'd0);

        // Reset asserted for three cycles while the data bits are on the line.
        set_in(1'b1, 4'hF);
        tick();
        set_in(1'b0, 4'h0);
        repeat (6) tick();
        chk("mid-frame busy", {7'd0, busy_m}, 8'd1);
        chk("mid-frame state DATA", {5'd0, st_m}, 8'd2);
        reset = 1'b1;
        tick();
        chk("abort serial_out", {7'd0, so_m}, 8'd1);
        chk("abort busy", {7'd0, busy_m}, 8'd0);
        chk("abort frame_done", {7'd0, fd_m}, 8'd0);
        chk("abort data_ready", {7'd0, rdy_m}, 8'd0);
        tick();
        chk("abort data_ready 2", {7'd0, rdy_m}, 8'd0);
        tick();
        chk("abort data_ready 3", {7'd0, rdy_m}, 8'd0);
        reset = 1'b0;
        #1;
        chk("release data_ready", {7'd0, rdy_m}, 8'd1);
        tick();
        chk("release line idle", {7'd0, so_m}, 8'd1);
        chk("release frame_done", {7'd0, fd_m}, 8'd0);
        send_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
